lpc_frame_sequencer: RTL and testbench

//  Sequences the LPC encoder datapath. Captures 8 kHz samples (d_clk strobe + v) into a ping-pong

---
 rtl/lpc_frame_sequencer_if.sv | 40 ++++
 rtl/lpc_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_lpc_frame_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_frame_sequencer_if.sv
// Sample-path, engine handshake and register-port signals of the LPC frame sequencer.
// The irq member exists only when LPC_SEQ_IRQ_EN is defined.
interface lpc_frame_sequencer_if #(
  parameter int AW = 9
);
  logic          d_clk;
  logic          v;
  logic [15:0]   x;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_wdata;
  logic          eng_start;
  logic          eng_bank;
  logic [15:0]   eng_len;
  logic          eng_done;
  logic [15:0]   address;
  logic          write;
  logic [15:0]   writedata;
  logic          read;
  logic [15:0]   readdata;
`ifdef LPC_SEQ_IRQ_EN
  logic          irq;
`endif

  modport master (
    input  d_clk, v, x, eng_done, address, write, writedata, read,
`ifdef LPC_SEQ_IRQ_EN
    output irq,
`endif
    output buf_we, buf_addr, buf_wdata, eng_start, eng_bank, eng_len, readdata
  );

  modport slave (
    output d_clk, v, x, eng_done, address, write, writedata, read,
`ifdef LPC_SEQ_IRQ_EN
    input  irq,
`endif
    input  buf_we, buf_addr, buf_wdata, eng_start, eng_bank, eng_len, readdata
  );
endinterface

// File: rtl/lpc_frame_sequencer.sv
// Ping-pong sample capture and analysis-engine sequencing for the LPC encoder.
// Optional interrupt logic (irq output, register 4) is built when LPC_SEQ_IRQ_EN is defined.
module lpc_frame_sequencer #(
  parameter int MAX_FRAME = 256,
  parameter int DEF_FRAME = 240,
  parameter int MIN_FRAME = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  lpc_frame_sequencer_if.master bus
);
  localparam int AW = $clog2(MAX_FRAME) + 1;
  localparam int IW = AW - 1;
  localparam logic [15:0] C_MAX = 16'(MAX_FRAME);
  localparam logic [15:0] C_MIN = 16'(MIN_FRAME);
  localparam logic [15:0] C_DEF = 16'(DEF_FRAME);

  typedef enum logic [1:0] {E_IDLE, E_START, E_BUSY} eng_state_t;

  eng_state_t    r_state, w_state_next;
  logic [2:0]    r_dclk_sync;
  logic [IW-1:0] r_idx;
  logic          r_cap_bank;
  logic [15:0]   r_len_active;
  logic [15:0]   r_frame_len;
  logic          r_enable;
  logic          r_overrun;
  logic [15:0]   r_frame_cnt;
  logic          r_buf_we;
  logic [AW-1:0] r_buf_addr;
  logic [15:0]   r_buf_wdata;
  logic          r_eng_bank;
  logic [15:0]   r_eng_len;
  logic [15:0]   r_readdata;
  logic [15:0]   w_rdata;
  logic [15:0]   w_irq_rdata;
  logic [15:0]   w_len_clamped;
  logic [7:0]    w_idx8;
  logic          w_strobe, w_wr_len, w_wr_ctrl, w_clear;
  logic          w_capture, w_last, w_handoff;
  logic          w_load_eng, w_overrun_set, w_frame_done, w_busy;

  // d_clk is asynchronous: two flops to settle it, the third detects the rising edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_dclk_sync <= '0;
    else          r_dclk_sync <= {r_dclk_sync[1:0], bus.d_clk};
  end

  assign w_strobe      = r_dclk_sync[1] & ~r_dclk_sync[2];
  assign w_wr_len      = bus.write && (bus.address == 16'd0);
  assign w_wr_ctrl     = bus.write && (bus.address == 16'd1);
  assign w_clear       = w_wr_ctrl & bus.writedata[1];
  assign w_capture     = w_strobe & r_enable & bus.v & ~w_clear;
  assign w_last        = ({{(16-IW){1'b0}}, r_idx} == (r_len_active - 16'd1));
  assign w_handoff     = w_capture & w_last;
  assign w_busy        = (r_state != E_IDLE);
  assign w_idx8        = 8'(r_idx);
  assign w_len_clamped = (bus.writedata < C_MIN) ? C_MIN :
                         (bus.writedata > C_MAX) ? C_MAX : bus.writedata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_we     <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_wdata  <= '0;
      r_idx        <= '0;
      r_cap_bank   <= 1'b0;
      r_len_active <= C_DEF;
    end else begin
      r_buf_we <= w_capture;
      if (w_capture) begin
        r_buf_addr  <= {r_cap_bank, r_idx};
        r_buf_wdata <= bus.x;
      end
      if (w_clear) begin
        r_idx      <= '0;
        r_cap_bank <= 1'b0;
      end else if (w_capture) begin
        if (w_last) begin
          r_idx        <= '0;
          r_cap_bank   <= ~r_cap_bank;
          r_len_active <= r_frame_len;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= E_IDLE;
    else          r_state <= w_state_next;
  end

  // A done coinciding with a handoff retires the old run first, so the new frame starts without overrun
  always_comb begin
    w_state_next  = r_state;
    w_load_eng    = 1'b0;
    w_overrun_set = 1'b0;
    w_frame_done  = 1'b0;
    if (w_clear) begin
      w_state_next = E_IDLE;
    end else begin
      case (r_state)
        E_IDLE: begin
          if (w_handoff) begin
            w_state_next = E_START;
            w_load_eng   = 1'b1;
          end
        end
        E_START: begin
          w_state_next  = E_BUSY;
          w_overrun_set = w_handoff;
        end
        E_BUSY: begin
          if (bus.eng_done) begin
            w_frame_done = 1'b1;
            if (w_handoff) begin
              w_state_next = E_START;
              w_load_eng   = 1'b1;
            end else begin
              w_state_next = E_IDLE;
            end
          end else begin
            w_overrun_set = w_handoff;
          end
        end
        default: w_state_next = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_eng_bank  <= 1'b0;
      r_eng_len   <= C_DEF;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load_eng) begin
        r_eng_bank <= r_cap_bank;
        r_eng_len  <= r_len_active;
      end
      if (w_clear) begin
        r_overrun   <= 1'b0;
        r_frame_cnt <= '0;
      end else begin
        if (w_overrun_set) r_overrun <= 1'b1;
        if (w_frame_done)  r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

`ifdef LPC_SEQ_IRQ_EN
  logic [1:0] r_irq_pend, r_irq_mask, w_irq_pend_next, w_irq_mask_next;
  logic       r_irq;
  logic       w_wr_irq;

  assign w_wr_irq = bus.write && (bus.address == 16'd4);

  // New events are OR-ed in after the write-1-to-clear so a simultaneous set survives
  always_comb begin
    w_irq_mask_next = r_irq_mask;
    w_irq_pend_next = r_irq_pend;
    if (w_wr_irq) begin
      w_irq_mask_next = bus.writedata[9:8];
      w_irq_pend_next = r_irq_pend & ~bus.writedata[1:0];
    end
    w_irq_pend_next = w_irq_pend_next | {w_overrun_set, w_frame_done};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_pend <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_pend <= w_irq_pend_next;
      r_irq_mask <= w_irq_mask_next;
      r_irq      <= |(w_irq_pend_next & w_irq_mask_next);
    end
  end

  assign w_irq_rdata = {6'b0, r_irq_mask, 6'b0, r_irq_pend};
  assign bus.irq     = r_irq;
`else
  assign w_irq_rdata = 16'h0000;
`endif

  always_comb begin
    w_rdata = 16'h0000;
    case (bus.address)
      16'd0:   w_rdata = r_frame_len;
      16'd1:   w_rdata = {15'b0, r_enable};
      16'd2:   w_rdata = {w_idx8, 5'b0, r_cap_bank, r_overrun, w_busy};
      16'd3:   w_rdata = r_frame_cnt;
      16'd4:   w_rdata = w_irq_rdata;
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_len <= C_DEF;
      r_enable    <= 1'b0;
      r_readdata  <= '0;
    end else begin
      if (w_wr_len)  r_frame_len <= w_len_clamped;
      if (w_wr_ctrl) r_enable    <= bus.writedata[0];
      if (bus.read)  r_readdata  <= w_rdata;
    end
  end

  assign bus.buf_we    = r_buf_we;
  assign bus.buf_addr  = r_buf_addr;
  assign bus.buf_wdata = r_buf_wdata;
  assign bus.eng_start = (r_state == E_START);
  assign bus.eng_bank  = r_eng_bank;
  assign bus.eng_len   = r_eng_len;
  assign bus.readdata  = r_readdata;
endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Scoreboard bench for lpc_frame_sequencer: randomized samples checked against a per-sample frame model.
// Define LPC_SEQ_IRQ_EN for both bench and RTL to also cover the interrupt register and irq output.
module tb_lpc_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  lpc_frame_sequencer_if bus ();

  lpc_frame_sequencer dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] bank; logic [15:0] len;  } start_t;

  wr_t         wrQ[$];
  start_t      startQ[$];
  logic [15:0] rdQ[$];
  string       rdNameQ[$];

  // Reference model state: what software would believe about the sequencer
  logic [15:0] mFrameLen, mLenActive, mFrameCnt;
  logic [7:0]  mIdx;
  logic        mEnable, mCapBank, mOverrun, mBusy;
  logic [1:0]  mIrqPend, mIrqMask;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mFrameLen  = 16'd240;
    mLenActive = 16'd240;
    mFrameCnt  = 16'd0;
    mIdx       = 8'd0;
    mEnable    = 1'b0;
    mCapBank   = 1'b0;
    mOverrun   = 1'b0;
    mBusy      = 1'b0;
    mIrqPend   = 2'b00;
    mIrqMask   = 2'b00;
  endfunction

  function automatic void modelDone();
    if (mBusy) begin
      mBusy       = 1'b0;
      mFrameCnt   = mFrameCnt + 16'd1;
      mIrqPend[0] = 1'b1;
    end
  endfunction

  function automatic void modelSample(input bit vIn, input logic [15:0] xIn, input bit doneSame);
    wr_t    w;
    start_t s;
    if (doneSame) modelDone();
    if (!(mEnable && vIn)) return;
    w.addr = {7'b0, mCapBank, mIdx};
    w.data = xIn;
    wrQ.push_back(w);
    if ({8'b0, mIdx} + 16'd1 == mLenActive) begin
      if (!mBusy) begin
        s.bank = {15'b0, mCapBank};
        s.len  = mLenActive;
        startQ.push_back(s);
        mBusy = 1'b1;
      end else begin
        mOverrun    = 1'b1;
        mIrqPend[1] = 1'b1;
      end
      mIdx       = 8'd0;
      mCapBank   = ~mCapBank;
      mLenActive = mFrameLen;
    end else begin
      mIdx = mIdx + 8'd1;
    end
  endfunction

  function automatic void modelWrite(input logic [15:0] a, input logic [15:0] d);
    case (a)
      16'd0: mFrameLen = (d < 16'd16) ? 16'd16 : (d > 16'd256) ? 16'd256 : d;
      16'd1: begin
        mEnable = d[0];
        if (d[1]) begin
          mIdx      = 8'd0;
          mCapBank  = 1'b0;
          mOverrun  = 1'b0;
          mFrameCnt = 16'd0;
          mBusy     = 1'b0;
        end
      end
`ifdef LPC_SEQ_IRQ_EN
      16'd4: begin
        mIrqPend = mIrqPend & ~d[1:0];
        mIrqMask = d[9:8];
      end
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    case (a)
      16'd0: return mFrameLen;
      16'd1: return {15'b0, mEnable};
      16'd2: return {mIdx, 5'b0, mCapBank, mOverrun, mBusy};
      16'd3: return mFrameCnt;
`ifdef LPC_SEQ_IRQ_EN
      16'd4: return {6'b0, mIrqMask, 6'b0, mIrqPend};
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One d_clk period; doneSame lines eng_done up with the edge-detected strobe so both land together
  task automatic applyStimulus(input bit vIn, input logic [15:0] xIn, input bit doneSame);
    modelSample(vIn, xIn, doneSame);
    bus.v     = vIn;
    bus.x     = xIn;
    bus.d_clk = 1'b1;
    tick();
    tick();
    if (doneSame) bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    tick();
    bus.d_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic engineDone();
    if (mBusy) begin
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      modelDone();
    end
  endtask

  task automatic regWrite(input logic [15:0] a, input logic [15:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick();
    bus.write = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic regRead(input logic [15:0] a, input string name);
    bus.address = a;
    bus.read    = 1'b1;
    rdQ.push_back(modelRead(a));
    rdNameQ.push_back(name);
    tick();
    bus.read = 1'b0;
    tick();
  endtask

  task automatic runStrobes(input int n, input int nZero, input bit doneOnLast, input int doneAt);
    bit zero [0:511];
    int p;
    for (int i = 0; i < 512; i++) zero[i] = 1'b0;
    for (int k = 0; k < nZero; ) begin
      p = int'($urandom_range(0, n - 2));
      if (!zero[p]) begin
        zero[p] = 1'b1;
        k++;
      end
    end
    for (int i = 0; i < n; i++) begin
      applyStimulus(!zero[i], 16'($urandom), doneOnLast && (i == n - 1));
      if (i == doneAt) engineDone();
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_buf_we",    {15'b0, bus.buf_we}, 16'd0);
    checkOutput("rst_buf_addr",  {7'b0, bus.buf_addr}, 16'd0);
    checkOutput("rst_buf_wdata", bus.buf_wdata, 16'd0);
    checkOutput("rst_eng_start", {15'b0, bus.eng_start}, 16'd0);
    checkOutput("rst_eng_bank",  {15'b0, bus.eng_bank}, 16'd0);
    checkOutput("rst_eng_len",   bus.eng_len, 16'd240);
    checkOutput("rst_readdata",  bus.readdata, 16'd0);
`ifdef LPC_SEQ_IRQ_EN
    checkOutput("rst_irq",       {15'b0, bus.irq}, 16'd0);
`endif
  endtask

`ifdef LPC_SEQ_IRQ_EN
  task automatic checkIrq(input string name);
    checkOutput(name, {15'b0, bus.irq}, {15'b0, |(mIrqPend & mIrqMask)});
  endtask
`endif

  wr_t         monWr;
  start_t      monSt;
  logic        rdPend = 1'b0;
  logic [15:0] monRd;
  string       monName;

  // Monitor: pops the scoreboard whenever the DUT presents a write, a start or read data
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_we) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_buf_we", {15'b0, bus.buf_we}, 16'd0);
        end else begin
          monWr = wrQ.pop_front();
          checkOutput("buf_addr",  {7'b0, bus.buf_addr}, monWr.addr);
          checkOutput("buf_wdata", bus.buf_wdata, monWr.data);
        end
      end
      if (bus.eng_start) begin
        if (startQ.size() == 0) begin
          checkOutput("unexpected_eng_start", {15'b0, bus.eng_start}, 16'd0);
        end else begin
          monSt = startQ.pop_front();
          checkOutput("eng_bank", {15'b0, bus.eng_bank}, monSt.bank);
          checkOutput("eng_len",  bus.eng_len, monSt.len);
        end
      end
      if (rdPend) begin
        monRd   = rdQ.pop_front();
        monName = rdNameQ.pop_front();
        checkOutput(monName, bus.readdata, monRd);
      end
      rdPend = bus.read;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.d_clk     = 1'b0;
    bus.v         = 1'b0;
    bus.x         = 16'h0000;
    bus.eng_done  = 1'b0;
    bus.address   = 16'h0000;
    bus.write     = 1'b0;
    bus.writedata = 16'h0000;
    bus.read      = 1'b0;
    rst_n         = 1'b0;
    modelReset();
    #12;
    checkResetState();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset values and first 240-sample frame");
    regRead(16'd0, "frame_len_reset");
    regRead(16'd2, "status_reset");
    regRead(16'd3, "frame_cnt_reset");
    regWrite(16'd0, 16'd240);
    regWrite(16'd1, 16'd1);
`ifdef LPC_SEQ_IRQ_EN
    regWrite(16'd4, 16'h0100);
`endif
    for (int i = 0; i < 241; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    repeat (3) tick();
    engineDone();
    regRead(16'd3, "frame_cnt_one");
    regRead(16'd2, "status_after_done");
`ifdef LPC_SEQ_IRQ_EN
    checkIrq("irq_frame_done");
    regWrite(16'd4, 16'h0101);
    checkIrq("irq_cleared");
    regRead(16'd4, "irq_reg_cleared");
`endif

    $display("[TB] overrun with eng_done held low");
    for (int i = 0; i < 479; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regRead(16'd2, "status_overrun");
    regRead(16'd3, "frame_cnt_overrun");

    $display("[TB] clear and frame length clamping");
    regWrite(16'd1, 16'd3);
    regRead(16'd2, "status_clear");
    regRead(16'd3, "frame_cnt_clear");
    regRead(16'd1, "ctrl_clear_bit");
    regWrite(16'd0, 16'd5);
    regRead(16'd0, "frame_len_min");
    regWrite(16'd0, 16'd1000);
    regRead(16'd0, "frame_len_max");
    regWrite(16'd0, 16'd16);
    regRead(16'd0, "frame_len_16");
    regWrite(16'd0, 16'd256);
    regRead(16'd0, "frame_len_256");
    regWrite(16'd0, 16'($urandom_range(17, 255)));
    regRead(16'd0, "frame_len_rand");
    regWrite(16'd0, 16'd240);

    $display("[TB] mid-frame length change, coincident done, dropped samples");
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regWrite(16'd0, 16'd80);
    for (int i = 0; i < 140; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regWrite(16'd0, 16'd240);
    runStrobes(90, 10, 1'b1, -1);
    regRead(16'd2, "status_coincident");
    runStrobes(250, 10, 1'b0, 5);
    regRead(16'd2, "status_after_250");
    engineDone();
    regRead(16'd3, "frame_cnt_before_clear");
    regWrite(16'd1, 16'd3);
    regRead(16'd2, "status_clear2");
    regRead(16'd3, "frame_cnt_clear2");

    $display("[TB] randomized frames");
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) regWrite(16'd0, 16'($urandom_range(10, 45)));
      applyStimulus($urandom_range(0, 7) != 0, 16'($urandom), mBusy && ($urandom_range(0, 9) == 0));
      if (mBusy && ($urandom_range(0, 3) == 0)) engineDone();
      if (i % 40 == 39) begin
        regRead(16'd2, "status_rand");
        regRead(16'd3, "frame_cnt_rand");
      end
    end

    $display("[TB] enable toggled mid-frame");
    regWrite(16'd1, 16'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regWrite(16'd1, 16'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regRead(16'd2, "status_disabled");
    regRead(16'd1, "ctrl_disabled");
    regWrite(16'd1, 16'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);

    $display("[TB] unmapped register");
    regWrite(16'd7, 16'hFFFF);
    regRead(16'd7, "unmapped_read");
    regRead(16'd0, "frame_len_after_unmapped");
`ifndef LPC_SEQ_IRQ_EN
    regRead(16'd4, "irq_reg_absent");
`else
    $display("[TB] irq set and clear in the same cycle");
    regWrite(16'd4, 16'h0303);
    for (int i = 0; i < 300 && !mBusy; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    checkOutput("engine_busy_for_irq", {15'b0, mBusy}, 16'd1);
    bus.eng_done  = 1'b1;
    bus.address   = 16'd4;
    bus.writedata = 16'h0301;
    bus.write     = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    bus.write    = 1'b0;
    modelWrite(16'd4, 16'h0301);
    modelDone();
    checkIrq("irq_set_wins");
    regRead(16'd4, "irq_reg_set_wins");
`endif

    $display("[TB] asynchronous reset mid-frame");
    repeat ($urandom_range(0, 5)) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState();
    modelReset();
    tick();
    rst_n = 1'b1;
    tick();
    regRead(16'd2, "status_after_reset");
    regRead(16'd0, "frame_len_after_reset");
    regWrite(16'd1, 16'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
    regRead(16'd2, "status_restart");

    repeat (4) tick();
    checkOutput("pending_writes", 16'(wrQ.size()), 16'd0);
    checkOutput("pending_starts", 16'(startQ.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
